// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle between a FIFO producer/consumer (master) and sync_fifo_param (slave).
interface sync_fifo_param_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 6
);
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr_en, wr_data, rd_en,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  wr_en, wr_data, rd_en,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered status flags, error pulses and a selectable
// registered-read or first-word-fall-through read port.
module sync_fifo_param #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 6,
   parameter int unsigned AF_LEVEL = (2**ADDR_W) - 4,
   parameter int unsigned AE_LEVEL = 4,
   parameter int unsigned FWFT     = 0
) (
   input  logic              clk,
   input  logic              rst,
   sync_fifo_param_if.slave  bus
);
   localparam int unsigned DEPTH = 2**ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CNT_W-1:0]  count_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;
   logic              full_q;
   logic              empty_q;
   logic              almost_full_q;
   logic              almost_empty_q;
   logic              overflow_q;
   logic              underflow_q;

   logic              wr_acc_c;
   logic              rd_acc_c;
   logic [ADDR_W-1:0] rd_ptr_next_c;
   logic [CNT_W-1:0]  count_after_rd_c;
   logic [CNT_W-1:0]  count_next_c;

   // Accept decisions use the registered flags, so a full FIFO can still pop
   // and an empty FIFO can still push in the same cycle.
   always_comb begin
      wr_acc_c         = bus.wr_en && !full_q;
      rd_acc_c         = bus.rd_en && !empty_q;
      rd_ptr_next_c    = rd_ptr + ADDR_W'(rd_acc_c);
      count_after_rd_c = count_q - CNT_W'(rd_acc_c);
      count_next_c     = count_after_rd_c + CNT_W'(wr_acc_c);
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_acc_c) begin
         mem[wr_ptr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count_q        <= '0;
         full_q         <= 1'b0;
         empty_q        <= 1'b1;
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         if (wr_acc_c) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         rd_ptr         <= rd_ptr_next_c;
         count_q        <= count_next_c;
         full_q         <= (count_next_c == CNT_W'(DEPTH));
         empty_q        <= (count_next_c == '0);
         almost_full_q  <= (count_next_c >= CNT_W'(AF_LEVEL));
         almost_empty_q <= (count_next_c <= CNT_W'(AE_LEVEL));
         overflow_q     <= bus.wr_en && full_q;
         underflow_q    <= bus.rd_en && empty_q;
      end
   end

   if (FWFT != 0) begin : g_fwft
      // Preload the next head word; a word written into a FIFO that is empty
      // after this edge's pop bypasses the array, which is not yet written.
      always_ff @(posedge clk) begin
         if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_valid_q <= (count_next_c != '0);
            if (count_next_c != '0) begin
               if (count_after_rd_c == '0) begin
                  rd_data_q <= bus.wr_data;
               end else begin
                  rd_data_q <= mem[rd_ptr_next_c];
               end
            end
         end
      end
   end else begin : g_reg
      always_ff @(posedge clk) begin
         if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_valid_q <= rd_acc_c;
            if (rd_acc_c) begin
               rd_data_q <= mem[rd_ptr];
            end
         end
      end
   end

   assign bus.rd_data      = rd_data_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = almost_full_q;
   assign bus.almost_empty = almost_empty_q;
   assign bus.count        = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a registered-read and a first-word-fall-through FIFO with identical
// stimulus and checks both against a queue model after every clock edge.
module tb_sync_fifo_param;
   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 6;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned AF    = 60;
   localparam int unsigned AE    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic          rd_en;
   logic [DW-1:0] wr_data;

   always #5 clk = ~clk;

   sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
   sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

   assign bus0.wr_en   = wr_en;
   assign bus0.wr_data = wr_data;
   assign bus0.rd_en   = rd_en;
   assign bus1.wr_en   = wr_en;
   assign bus1.wr_data = wr_data;
   assign bus1.rd_en   = rd_en;

   sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0))
      dut0 (.clk(clk), .rst(rst), .bus(bus0));
   sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1))
      dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // Reference model: contents as a queue, expected port values per read mode
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_rd0, m_rd1;
   logic          m_vld0, m_vld1, m_ov, m_un;
   int            n_vec, n_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic w, input logic [DW-1:0] d, input logic rd);
      bit was_full, was_empty;
      int sz;
      @(negedge clk);
      rst = r; wr_en = w; wr_data = d; rd_en = rd;
      @(posedge clk);
      #1;
      if (r) begin
         q.delete();
         m_rd0 = '0; m_rd1 = '0; m_vld0 = 1'b0; m_vld1 = 1'b0; m_ov = 1'b0; m_un = 1'b0;
      end else begin
         was_full  = (q.size() == DEPTH);
         was_empty = (q.size() == 0);
         m_ov   = w && was_full;
         m_un   = rd && was_empty;
         m_vld0 = 1'b0;
         if (rd && !was_empty) begin
            m_rd0  = q.pop_front();
            m_vld0 = 1'b1;
         end
         if (w && !was_full) q.push_back(d);
         if (q.size() != 0) m_rd1 = q[0];
         m_vld1 = (q.size() != 0);
      end
      sz = q.size();
      chk("count0",       32'(bus0.count),     32'(sz));
      chk("count1",       32'(bus1.count),     32'(sz));
      chk("full",         32'(bus0.full),      32'(sz == DEPTH));
      chk("empty",        32'(bus0.empty),     32'(sz == 0));
      chk("almost_full",  32'(bus0.almost_full),  32'(sz >= AF));
      chk("almost_empty", 32'(bus0.almost_empty), 32'(sz <= AE));
      chk("empty1",       32'(bus1.empty),     32'(sz == 0));
      chk("overflow",     32'(bus0.overflow),  32'(m_ov));
      chk("underflow",    32'(bus0.underflow), 32'(m_un));
      chk("overflow1",    32'(bus1.overflow),  32'(m_ov));
      chk("underflow1",   32'(bus1.underflow), 32'(m_un));
      chk("rd_valid_reg", 32'(bus0.rd_valid),  32'(m_vld0));
      chk("rd_data_reg",  32'(bus0.rd_data),   32'(m_rd0));
      chk("rd_valid_fwft",32'(bus1.rd_valid),  32'(m_vld1));
      chk("rd_data_fwft", 32'(bus1.rd_data),   32'(m_rd1));
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
      m_rd0 = '0; m_rd1 = '0; m_vld0 = 1'b0; m_vld1 = 1'b0; m_ov = 1'b0; m_un = 1'b0;

      // Reset, including reset winning over simultaneous requests
      step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b1, 8'hAA, 1'b1);

      // Fill with 0x01..0x40, then an overflowing write
      for (int i = 1; i <= 64; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
      step(1'b0, 1'b1, 8'hFF, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Drain in order, then an underflowing read
      for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Simultaneous requests at empty, then at full
      step(1'b0, 1'b1, 8'($urandom), 1'b1);
      while (q.size() < DEPTH) step(1'b0, 1'b1, 8'($urandom), 1'b0);
      step(1'b0, 1'b1, 8'($urandom), 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Steady state at 10 words for 100 cycles, wrapping the pointers
      while (q.size() > 10) step(1'b0, 1'b0, 8'h00, 1'b1);
      repeat (100) step(1'b0, 1'b1, 8'($urandom), 1'b1);

      // Mid-operation reset with a write pending, then write/read back
      while (q.size() < 30) step(1'b0, 1'b1, 8'($urandom), 1'b0);
      step(1'b1, 1'b1, 8'($urandom), 1'b0);
      step(1'b0, 1'b1, 8'h3C, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);

      // Fall-through of a single word written to an empty FIFO
      step(1'b0, 1'b1, 8'hA5, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Random traffic: write-heavy, read-heavy, balanced, with rare resets
      repeat (250) step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                        8'($urandom), $urandom_range(0, 3) == 0);
      repeat (250) step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                        8'($urandom), $urandom_range(0, 3) != 0);
      repeat (250) step($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)),
                        8'($urandom), 1'($urandom_range(0, 1)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL provide parameter DATA_W, 8, data word width in bits.
REQ-002 SHALL provide parameter ADDR_W, 6, address width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL provide parameter AF_LEVEL, DEPTH-4, count at or above which almost_full asserts.
REQ-004 SHALL provide parameter AE_LEVEL, 4, count at or below which almost_empty asserts.
REQ-005 SHALL provide parameter FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL provide port clk  input  1  rising-edge clock.
REQ-007 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL provide port wr_en  input  1  write request.
REQ-009 SHALL provide port wr_data  input  DATA_W  write data.
REQ-010 SHALL provide port rd_en  input  1  read (pop) request.
REQ-011 SHALL provide port rd_data  output  DATA_W  read data.
REQ-012 SHALL provide port rd_valid  output  1  rd_data holds a valid popped/head word.
REQ-013 SHALL provide port full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL provide port count  output  ADDR_W+1  stored word count, 0..DEPTH.
REQ-015 SHALL provide port overflow, underflow  output  1 each  single-cycle error pulses.

Function
REQ-016 Write SHALL be accepted when wr_en=1 and full=0; data stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-017 Read SHALL be accepted when rd_en=1 and empty=0; rd_ptr increments modulo DEPTH.
REQ-018 Accepted write and accepted read in one cycle SHALL leave count unchanged; both pointers advance.
REQ-019 Write alone SHALL increment count, read alone SHALL decrement count, at the same edge.
REQ-020 full, empty, almost_full, almost_empty SHALL be registered, reflect count after each edge: full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL), almost_empty=(count<=AE_LEVEL).
REQ-021 Write while full SHALL be dropped (no memory, pointer or count change) and overflow SHALL pulse high the next cycle for one cycle.
REQ-022 Read while empty SHALL be ignored and underflow SHALL pulse high the next cycle for one cycle.
REQ-023 At full, simultaneous wr_en and rd_en SHALL accept the read only; write dropped, overflow pulses.
REQ-024 At empty, simultaneous wr_en and rd_en SHALL accept the write only; underflow pulses.
REQ-025 FWFT=0: rd_data SHALL update one cycle after an accepted read with the popped word, rd_valid SHALL pulse that cycle; otherwise rd_data holds, rd_valid=0.
REQ-026 FWFT=1: rd_data SHALL present the head word and rd_valid SHALL equal !empty; a write to an empty FIFO SHALL appear on rd_data with rd_valid=1 one cycle after the write edge.
REQ-027 Pointers SHALL be ADDR_W bits and wrap from DEPTH-1 to 0 without loss of data order.
REQ-028 Storage SHALL be a DEPTH x DATA_W array without reset.

Reset
REQ-029 rst=1 at a clock edge SHALL clear pointers and count to 0, set empty=1, almost_empty=1, full=0, almost_full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
REQ-030 rst SHALL take priority over wr_en/rd_en in the same cycle; FIFO contents are discarded logically.
REQ-031 rst asserted mid-operation (partly full) SHALL yield empty state one cycle later; the next write is read back first.

Verification (DATA_W=8, ADDR_W=6, AF_LEVEL=60, AE_LEVEL=4)
REQ-032 Reset then write 0x01..0x40 (64 words) -> full=1, count=64, almost_full from count 60; a 65th write 0xFF -> overflow pulses once, count stays 64.
REQ-033 From full, read 64 words with FWFT=0 -> rd_data 0x01..0x40 in order one cycle after each rd_en, empty=1 after last, extra read -> underflow pulse.
REQ-034 Count=10, wr_en and rd_en held 100 cycles -> count stays 10, pointers wrap past 63, data order preserved.
REQ-035 FWFT=1, write 0xA5 to empty -> next cycle rd_data=0xA5, rd_valid=1 with no rd_en; rd_en pops, empty=1.
REQ-036 Count=30, assert rst one cycle with wr_en=1 -> count=0, empty=1, write ignored; then write 0x3C, read -> 0x3C.
REQ-037 Empty with wr_en=rd_en=1 -> count=1, underflow pulse; full with both -> count=63, overflow pulse.
